// File: rtl/adsr_envelope_gen.sv
// rtl/adsr_envelope_gen.sv - ADSR envelope generator with prescaled, saturating per-phase ramps
module adsr_envelope_gen #(
  parameter int WIDTH  = 8,
  parameter int RATE_W = 8,
  parameter int STEP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gate,
  input  logic [RATE_W-1:0] attack_rate,
  input  logic [RATE_W-1:0] decay_rate,
  input  logic [WIDTH-1:0]  sustain_level,
  input  logic [RATE_W-1:0] release_rate,
  output logic [WIDTH-1:0]  amplitude,
  output logic [2:0]        phase,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_ATTACK  = 3'd1,
    PH_DECAY   = 3'd2,
    PH_SUSTAIN = 3'd3,
    PH_RELEASE = 3'd4
  } phase_e;

  localparam logic [WIDTH:0] MAX_X  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  phase_e             phase_q, phase_d;
  logic [WIDTH-1:0]   amp_q, amp_d;
  logic [RATE_W-1:0]  cnt_q, cnt_d;
  logic               gate_q, gate_d;
  logic               done_q, done_d;

  logic               rise, fall, step_hit;
  logic [RATE_W-1:0]  cur_rate;
  logic [WIDTH:0]     amp_x, sus_x, amp_up, amp_dn, amp_gap;

  always_comb begin
    phase_d  = phase_q;
    amp_d    = amp_q;
    cnt_d    = cnt_q;
    gate_d   = gate;
    done_d   = 1'b0;
    rise     = gate & ~gate_q;
    fall     = ~gate & gate_q;
    amp_x    = {1'b0, amp_q};
    sus_x    = {1'b0, sustain_level};
    amp_up   = amp_x + STEP_X;
    amp_dn   = amp_x - STEP_X;
    amp_gap  = amp_x - sus_x;

    case (phase_q)
      PH_ATTACK:  cur_rate = attack_rate;
      PH_DECAY:   cur_rate = decay_rate;
      PH_RELEASE: cur_rate = release_rate;
      default:    cur_rate = '0;
    endcase
    // >= rather than == so a rate lowered mid-count steps on the next edge
    step_hit = (cnt_q >= cur_rate);

    if (rise) begin
      phase_d = PH_ATTACK;
      cnt_d   = '0;
    end else if (fall && (phase_q == PH_ATTACK || phase_q == PH_DECAY ||
                          phase_q == PH_SUSTAIN)) begin
      phase_d = PH_RELEASE;
      cnt_d   = '0;
    end else begin
      case (phase_q)
        PH_IDLE: cnt_d = '0;
        PH_ATTACK: begin
          if (step_hit) begin
            cnt_d = '0;
            if (amp_up >= MAX_X) begin
              amp_d   = MAX_X[WIDTH-1:0];
              phase_d = PH_DECAY;
            end else begin
              amp_d = amp_up[WIDTH-1:0];
            end
          end else begin
            cnt_d = cnt_q + RATE_W'(1);
          end
        end
        PH_DECAY: begin
          if (amp_q <= sustain_level) begin
            phase_d = PH_SUSTAIN;
            cnt_d   = '0;
          end else if (step_hit) begin
            cnt_d = '0;
            if (amp_gap <= STEP_X) begin
              amp_d   = sustain_level;
              phase_d = PH_SUSTAIN;
            end else begin
              amp_d = amp_dn[WIDTH-1:0];
            end
          end else begin
            cnt_d = cnt_q + RATE_W'(1);
          end
        end
        PH_SUSTAIN: begin
          amp_d = sustain_level;
          cnt_d = '0;
        end
        PH_RELEASE: begin
          if (amp_q == '0) begin
            phase_d = PH_IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else if (step_hit) begin
            cnt_d = '0;
            if (amp_x <= STEP_X) begin
              amp_d   = '0;
              phase_d = PH_IDLE;
              done_d  = 1'b1;
            end else begin
              amp_d = amp_dn[WIDTH-1:0];
            end
          end else begin
            cnt_d = cnt_q + RATE_W'(1);
          end
        end
        default: begin
          phase_d = PH_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      amp_q   <= '0;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      amp_q   <= amp_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
    end
  end

  assign amplitude = amp_q;
  assign phase     = phase_q;
  assign busy      = (phase_q != PH_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// tb/tb_adsr_envelope_gen.sv - bench for adsr_envelope_gen, STEP=1 and STEP=7 instances
module tb_adsr_envelope_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       gate = 1'b0;
  logic [7:0] attack_rate = '0, decay_rate = '0, release_rate = '0, sustain_level = '0;
  logic [7:0] amp0, amp1;
  logic [2:0] ph0, ph1;
  logic       busy0, busy1, done0, done1;

  int total = 0;
  int bad = 0;

  int m_amp[2], m_ph[2], m_cnt[2], m_done[2], m_g[2];
  int stp[2] = '{1, 7};

  always #5 clk = ~clk;

  adsr_envelope_gen #(.WIDTH(8), .RATE_W(8), .STEP(1)) u_dut (
    .clk(clk), .rst(rst), .gate(gate), .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .amplitude(amp0), .phase(ph0), .busy(busy0), .done(done0));

  adsr_envelope_gen #(.WIDTH(8), .RATE_W(8), .STEP(7)) u_dut7 (
    .clk(clk), .rst(rst), .gate(gate), .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .amplitude(amp1), .phase(ph1), .busy(busy1), .done(done1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_amp[i] = 0; m_ph[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_g[i] = 0;
    end
  endtask

  // Reference: 0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE; amplitude as plain integer
  task automatic model_edge();
    int g, rise, fall, rate, sus;
    g = int'(gate);
    sus = int'(sustain_level);
    for (int i = 0; i < 2; i++) begin
      rise = (g == 1 && m_g[i] == 0) ? 1 : 0;
      fall = (g == 0 && m_g[i] == 1) ? 1 : 0;
      m_g[i] = g;
      m_done[i] = 0;
      rate = (m_ph[i] == 1) ? int'(attack_rate) : (m_ph[i] == 2) ? int'(decay_rate) :
             (m_ph[i] == 4) ? int'(release_rate) : 0;
      if (rise == 1) begin
        m_ph[i] = 1; m_cnt[i] = 0;
      end else if (fall == 1 && m_ph[i] >= 1 && m_ph[i] <= 3) begin
        m_ph[i] = 4; m_cnt[i] = 0;
      end else if (m_ph[i] == 3) begin
        m_amp[i] = sus;
      end else if (m_ph[i] == 2 && m_amp[i] <= sus) begin
        m_ph[i] = 3;
      end else if (m_ph[i] == 4 && m_amp[i] == 0) begin
        m_ph[i] = 0; m_done[i] = 1;
      end else if (m_ph[i] == 0) begin
        m_cnt[i] = 0;
      end else if (m_cnt[i] < rate) begin
        m_cnt[i]++;
      end else begin
        m_cnt[i] = 0;
        if (m_ph[i] == 1) begin
          m_amp[i] = (m_amp[i] + stp[i] > 255) ? 255 : m_amp[i] + stp[i];
          if (m_amp[i] == 255) m_ph[i] = 2;
        end else if (m_ph[i] == 2) begin
          m_amp[i] = (m_amp[i] - stp[i] < sus) ? sus : m_amp[i] - stp[i];
          if (m_amp[i] == sus) m_ph[i] = 3;
        end else begin
          m_amp[i] = (m_amp[i] - stp[i] < 0) ? 0 : m_amp[i] - stp[i];
          if (m_amp[i] == 0) begin m_ph[i] = 0; m_done[i] = 1; end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("amp_s1", 32'(amp0), 32'(m_amp[0]));
    chk("phase_s1", 32'(ph0), 32'(m_ph[0]));
    chk("busy_s1", 32'(busy0), 32'(m_ph[0] != 0));
    chk("done_s1", 32'(done0), 32'(m_done[0]));
    chk("amp_s7", 32'(amp1), 32'(m_amp[1]));
    chk("phase_s7", 32'(ph1), 32'(m_ph[1]));
    chk("busy_s7", 32'(busy1), 32'(m_ph[1] != 0));
    chk("done_s7", 32'(done1), 32'(m_done[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((ph0 != 3'd0 || ph1 != 3'd0) && n < lim) begin
      tick();
      n++;
    end
    chk("idle_timeout_s1", 32'(ph0), 32'd0);
    chk("idle_timeout_s7", 32'(ph1), 32'd0);
  endtask

  initial begin
    int dones, n, hold;
    // reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_amp", 32'(amp0), 32'd0);
    chk("rst_phase", 32'(ph0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    model_reset();
    @(negedge clk) rst = 1'b0;

    // full envelope, rates 0, sustain 200
    sustain_level = 8'd200;
    gate = 1'b1;
    tick();
    for (int e = 1; e <= 320; e++) begin
      tick();
      if (e == 1) chk("t1_amp_at1", 32'(amp0), 32'd1);
      if (e == 255) begin
        chk("t1_amp_at255", 32'(amp0), 32'd255);
        chk("t1_phase_at255", 32'(ph0), 32'd2);
      end
      if (e == 310) begin
        chk("t1_amp_at310", 32'(amp0), 32'd200);
        chk("t1_phase_at310", 32'(ph0), 32'd3);
      end
    end
    gate = 1'b0;
    wait_idle(600);

    // STEP=7 saturation and sustain clamp/tracking
    sustain_level = 8'd250;
    gate = 1'b1;
    tick();
    for (int e = 1; e <= 45; e++) begin
      tick();
      if (e == 37) begin
        chk("t5_sat_amp", 32'(amp1), 32'd255);
        chk("t5_sat_phase", 32'(ph1), 32'd2);
      end
      if (e == 38) begin
        chk("t5_clamp_amp", 32'(amp1), 32'd250);
        chk("t5_clamp_phase", 32'(ph1), 32'd3);
      end
    end
    sustain_level = 8'd10;
    tick();
    chk("t5_track_amp", 32'(amp1), 32'd10);
    gate = 1'b0;
    wait_idle(600);

    // fall mid-attack at amp=100, release to zero
    sustain_level = 8'd200;
    gate = 1'b1;
    tick();
    repeat (100) tick();
    chk("t3_amp100", 32'(amp0), 32'd100);
    gate = 1'b0;
    tick();
    chk("t3_rel_phase", 32'(ph0), 32'd4);
    chk("t3_rel_amp", 32'(amp0), 32'd100);
    dones = 0;
    repeat (120) begin
      tick();
      dones += int'(done0);
    end
    chk("t3_done_count", 32'(dones), 32'd1);
    chk("t3_final_phase", 32'(ph0), 32'd0);
    chk("t3_final_amp", 32'(amp0), 32'd0);

    // retrigger during release at amp=50
    gate = 1'b1;
    tick();
    repeat (79) tick();
    gate = 1'b0;
    tick();
    n = 0;
    while (amp0 != 8'd50 && n < 100) begin
      tick();
      n++;
    end
    chk("t4_reach50", 32'(amp0), 32'd50);
    gate = 1'b1;
    tick();
    chk("t4_phase", 32'(ph0), 32'd1);
    chk("t4_amp_held", 32'(amp0), 32'd50);
    chk("t4_no_done", 32'(done0), 32'd0);
    tick();
    chk("t4_amp51", 32'(amp0), 32'd51);
    tick();
    chk("t4_amp52", 32'(amp0), 32'd52);
    gate = 1'b0;
    wait_idle(600);

    // attack prescaler, rate 3
    attack_rate = 8'd3;
    gate = 1'b1;
    tick();
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 3) chk("t2_amp_at3", 32'(amp0), 32'd0);
      if (e == 4) chk("t2_amp_at4", 32'(amp0), 32'd1);
      if (e == 15) chk("t2_amp_at15", 32'(amp0), 32'd3);
      if (e == 16) chk("t2_amp_at16", 32'(amp0), 32'd4);
    end
    gate = 1'b0;
    wait_idle(3000);

    // randomized gate/rate/sustain against the model
    for (int c = 0; c < 12; c++) begin
      hold = int'($urandom_range(5, 300));
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(0, hold - 1) == 0) gate = ~gate;
        if ($urandom_range(0, 99) == 0) begin
          attack_rate   = 8'($urandom_range(0, 3));
          decay_rate    = 8'($urandom_range(0, 3));
          release_rate  = 8'($urandom_range(0, 3));
          sustain_level = 8'($urandom_range(0, 255));
        end
        tick();
      end
    end

    // async reset mid-decay with gate held high
    gate = 1'b0;
    attack_rate = '0; decay_rate = '0; release_rate = '0;
    wait_idle(3000);
    sustain_level = 8'd100;
    gate = 1'b1;
    tick();
    repeat (260) tick();
    chk("t6_in_decay", 32'(ph0), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_amp", 32'(amp0), 32'd0);
    chk("t6_rst_phase", 32'(ph0), 32'd0);
    chk("t6_rst_busy", 32'(busy0), 32'd0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    tick();
    chk("t6_restart_phase", 32'(ph0), 32'd1);
    chk("t6_restart_amp", 32'(amp0), 32'd0);
    tick();
    chk("t6_first_step", 32'(amp0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
